lsu_port: RTL and testbench

LSU_PORT -- requirements
Module: lsu_port

---
 rtl/lsu_pkg.sv | 38 +++
 rtl/lsu_port_load_align.sv | 29 ++
 rtl/lsu_port.sv | 164 ++++++++++++++++
 tb/tb_lsu_port.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store port: access encodings,
// FSM states and size masks.
package lsu_pkg;

    localparam logic [2:0] F3_B   = 3'b000;
    localparam logic [2:0] F3_H   = 3'b001;
    localparam logic [2:0] F3_W   = 3'b010;
    localparam logic [2:0] F3_D   = 3'b011;
    localparam logic [2:0] F3_BU  = 3'b100;
    localparam logic [2:0] F3_HU  = 3'b101;
    localparam logic [2:0] F3_WU  = 3'b110;
    localparam logic [2:0] F3_BAD = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_RESP
    } state_e;

    localparam logic [63:0] MASK_B = 64'h0000_0000_0000_00FF;
    localparam logic [63:0] MASK_H = 64'h0000_0000_0000_FFFF;
    localparam logic [63:0] MASK_W = 64'h0000_0000_FFFF_FFFF;
    localparam logic [63:0] MASK_D = 64'hFFFF_FFFF_FFFF_FFFF;

    // funct3[1:0] alone selects the access width
    function automatic logic [63:0] size_mask(input logic [1:0] sz);
        logic [63:0] m;
        unique case (sz)
            2'b00: m = MASK_B;
            2'b01: m = MASK_H;
            2'b10: m = MASK_W;
            2'b11: m = MASK_D;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/lsu_port_load_align.sv
// Load data alignment: shift the doubleword down to the accessed
// byte, truncate to the access size, then sign- or zero-extend.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [63:0] data,
    input  logic [2:0]  offset,
    input  logic [2:0]  funct3,
    output logic [63:0] rdata
);

    logic [63:0] sh;

    always_comb begin
        sh    = data >> {offset, 3'b000};
        rdata = '0;
        case (funct3)
            F3_B:    rdata = {{56{sh[7]}}, sh[7:0]};
            F3_H:    rdata = {{48{sh[15]}}, sh[15:0]};
            F3_W:    rdata = {{32{sh[31]}}, sh[31:0]};
            F3_D:    rdata = sh;
            F3_BU:   rdata = {56'd0, sh[7:0]};
            F3_HU:   rdata = {48'd0, sh[15:0]};
            F3_WU:   rdata = {32'd0, sh[31:0]};
            default: rdata = '0;
        endcase
    end

endmodule

// File: rtl/lsu_port.sv
// Single-outstanding load/store port between the pipeline and a
// doubleword memory, with alignment checks and a response timeout.
module lsu_port
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_wen,
    input  logic [2:0]  in_funct3,
    input  logic [63:0] in_addr,
    input  logic [63:0] in_wdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_rdata,
    output logic        out_misalign,
    output logic        out_illegal,
    output logic        out_timeout,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_wen,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic [63:0] mem_mask,
    input  logic        mem_resp_valid,
    input  logic [63:0] mem_resp_data
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TMO = CW'(TIMEOUT_CYCLES);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic          wen_q, wen_d;
    logic [2:0]    f3_q, f3_d;
    logic [63:0]   addr_q, addr_d;
    logic [63:0]   wdata_q, wdata_d;
    logic [63:0]   rdata_q, rdata_d;
    logic          misalign_q, misalign_d;
    logic          illegal_q, illegal_d;
    logic          timeout_q, timeout_d;

    logic          illegal_in, misalign_in, tmo_hit;
    logic [63:0]   load_rdata, mask_full;

    lsu_load_align u_align (
        .data   (mem_resp_data),
        .offset (addr_q[2:0]),
        .funct3 (f3_q),
        .rdata  (load_rdata)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            wen_q      <= 1'b0;
            f3_q       <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            misalign_q <= 1'b0;
            illegal_q  <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wen_q      <= wen_d;
            f3_q       <= f3_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            misalign_q <= misalign_d;
            illegal_q  <= illegal_d;
            timeout_q  <= timeout_d;
        end
    end

    always_comb begin
        illegal_in  = (in_funct3 == F3_BAD) || (in_funct3[2] && in_wen);
        misalign_in = 1'b0;
        unique case (in_funct3[1:0])
            2'b01:   misalign_in = in_addr[0];
            2'b10:   misalign_in = |in_addr[1:0];
            2'b11:   misalign_in = |in_addr[2:0];
            default: misalign_in = 1'b0;
        endcase

        cnt_inc    = cnt_q + CW'(1);
        tmo_hit    = (cnt_inc == TMO);
        state_d    = state_q;
        cnt_d      = cnt_q;
        wen_d      = wen_q;
        f3_d       = f3_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        misalign_d = misalign_q;
        illegal_d  = illegal_q;
        timeout_d  = timeout_q;

        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    wen_d      = in_wen;
                    f3_d       = in_funct3;
                    addr_d     = in_addr;
                    wdata_d    = in_wdata;
                    rdata_d    = '0;
                    timeout_d  = 1'b0;
                    illegal_d  = illegal_in;
                    misalign_d = !illegal_in && misalign_in;
                    cnt_d      = '0;
                    state_d    = (illegal_in || misalign_in) ? ST_RESP : ST_REQ;
                end
            end
            ST_REQ: begin
                if (tmo_hit) begin
                    timeout_d = 1'b1;
                    rdata_d   = '0;
                    state_d   = ST_RESP;
                end else begin
                    cnt_d = cnt_inc;
                    if (mem_req_ready) state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // a response landing on the timeout cycle still wins
                if (mem_resp_valid) begin
                    rdata_d = wen_q ? 64'd0 : load_rdata;
                    state_d = ST_RESP;
                end else if (tmo_hit) begin
                    timeout_d = 1'b1;
                    rdata_d   = '0;
                    state_d   = ST_RESP;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_RESP: begin
                if (out_ready) state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        mask_full     = size_mask(f3_q[1:0]) << {addr_q[2:0], 3'b000};
        in_ready      = (state_q == ST_IDLE);
        mem_req_valid = (state_q == ST_REQ);
        mem_wen       = mem_req_valid && wen_q;
        mem_addr      = mem_req_valid ? {addr_q[63:3], 3'b000} : 64'd0;
        mem_mask      = mem_req_valid ? mask_full : 64'd0;
        mem_wdata     = mem_wen ? ((wdata_q << {addr_q[2:0], 3'b000}) & mask_full) : 64'd0;
        out_valid     = (state_q == ST_RESP);
        out_rdata     = out_valid ? rdata_q : 64'd0;
        out_misalign  = out_valid && misalign_q;
        out_illegal   = out_valid && illegal_q;
        out_timeout   = out_valid && timeout_q;
    end

endmodule

// File: tb/tb_lsu_port.sv
// Randomized and directed bench for lsu_port against an
// arithmetic reference model of the access rules.
module tb_lsu_port;

    localparam int TMO = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, in_wen;
    logic [2:0]  in_funct3;
    logic [63:0] in_addr, in_wdata;
    logic        out_valid, out_ready;
    logic [63:0] out_rdata;
    logic        out_misalign, out_illegal, out_timeout;
    logic        mem_req_valid, mem_req_ready, mem_wen;
    logic [63:0] mem_addr, mem_wdata, mem_mask;
    logic        mem_resp_valid;
    logic [63:0] mem_resp_data;
    logic [5:0]  st;

    int n_checks = 0;
    int n_fail = 0;

    lsu_port #(.TIMEOUT_CYCLES(TMO)) dut (
        .clock          (clock),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_wen         (in_wen),
        .in_funct3      (in_funct3),
        .in_addr        (in_addr),
        .in_wdata       (in_wdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_rdata      (out_rdata),
        .out_misalign   (out_misalign),
        .out_illegal    (out_illegal),
        .out_timeout    (out_timeout),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_wen        (mem_wen),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_mask       (mem_mask),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data)
    );

    always #5 clock = ~clock;

    assign st = {out_valid, in_ready, mem_req_valid,
                 out_illegal, out_misalign, out_timeout};

    function automatic int m_bytes(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic logic [63:0] m_lowmask(input int bytes);
        return (bytes == 8) ? ~64'd0 : ((64'd1 << (8 * bytes)) - 64'd1);
    endfunction

    function automatic logic [63:0] m_mask(input logic [2:0] f3, input logic [63:0] a);
        return m_lowmask(m_bytes(f3)) << (8 * (a % 8));
    endfunction

    function automatic logic m_illegal(input logic w, input logic [2:0] f3);
        return (f3 == 3'd7) || (f3 >= 3'd4 && w);
    endfunction

    function automatic logic m_misalign(input logic w, input logic [2:0] f3, input logic [63:0] a);
        return !m_illegal(w, f3) && ((a % m_bytes(f3)) != 0);
    endfunction

    function automatic logic [63:0] m_load(input logic [2:0] f3, input logic [63:0] a,
                                           input logic [63:0] resp);
        int bytes = m_bytes(f3);
        logic [63:0] lm = m_lowmask(bytes);
        logic [63:0] v = (resp >> (8 * (a % 8))) & lm;
        if (f3 < 3'd3 && v[8 * bytes - 1]) v = v | ~lm;
        return v;
    endfunction

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic scramble_inputs();
        in_wen    = 1'($urandom);
        in_funct3 = 3'($urandom);
        in_addr   = {$urandom, $urandom};
        in_wdata  = {$urandom, $urandom};
    endtask

    task automatic run_txn(input logic w, input logic [2:0] f3, input logic [63:0] a,
                           input logic [63:0] wd, input logic [63:0] resp,
                           input int d1, input int d2, input int hold, input string tag);
        logic        e_ill = m_illegal(w, f3);
        logic        e_mis = m_misalign(w, f3, a);
        logic        bad = e_ill || e_mis;
        logic [63:0] e_mask = m_mask(f3, a);
        logic [63:0] e_wd = w ? ((wd << (8 * (a % 8))) & e_mask) : 64'd0;
        logic [63:0] e_rd = (bad || w) ? 64'd0 : m_load(f3, a, resp);
        logic [63:0] e_addr = a - (a % 8);
        n_checks++;
        if (st !== 6'b010000) begin
            n_fail++;
            $display("FAIL %s idle status got=%b exp=010000", tag, st);
        end
        in_valid = 1'b1; in_wen = w; in_funct3 = f3; in_addr = a; in_wdata = wd;
        tick();
        in_valid = 1'b0;
        scramble_inputs();
        if (!bad) begin
            for (int i = 0; i <= d1; i++) begin
                n_checks++;
                if ({st, mem_wen} !== {6'b001000, w}) begin
                    n_fail++;
                    $display("FAIL %s req status got=%b exp=%b", tag, {st, mem_wen}, {6'b001000, w});
                end
                n_checks++;
                if ({mem_addr, mem_mask, mem_wdata} !== {e_addr, e_mask, e_wd}) begin
                    n_fail++;
                    $display("FAIL %s req fields addr/mask/wdata got=%h/%h/%h exp=%h/%h/%h",
                             tag, mem_addr, mem_mask, mem_wdata, e_addr, e_mask, e_wd);
                end
                mem_req_ready  = (i == d1);
                mem_resp_valid = (i < d1) ? 1'($urandom) : 1'b0;
                mem_resp_data  = {$urandom, $urandom};
                tick();
            end
            mem_req_ready = 1'b0;
            for (int i = 0; i <= d2; i++) begin
                n_checks++;
                if (st !== 6'b000000) begin
                    n_fail++;
                    $display("FAIL %s wait status got=%b exp=000000", tag, st);
                end
                mem_resp_valid = (i == d2);
                mem_resp_data  = (i == d2) ? resp : {$urandom, $urandom};
                tick();
            end
            mem_resp_valid = 1'b0;
        end
        for (int i = 0; i <= hold; i++) begin
            n_checks++;
            if ({st, out_rdata} !== {3'b100, e_ill, e_mis, 1'b0, e_rd}) begin
                n_fail++;
                $display("FAIL %s resp status/rdata got=%b/%h exp=%b/%h",
                         tag, st, out_rdata, {3'b100, e_ill, e_mis, 1'b0}, e_rd);
            end
            in_valid  = (i < hold) ? 1'($urandom) : 1'b0;
            out_ready = (i == hold);
            tick();
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        n_checks++;
        if (st !== 6'b010000) begin
            n_fail++;
            $display("FAIL %s post status got=%b exp=010000", tag, st);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0; mem_req_ready = 1'b0;
        mem_resp_valid = 1'b0; mem_resp_data = '0;
        in_wen = 1'b0; in_funct3 = '0; in_addr = '0; in_wdata = '0;
        tick();
        tick();
        n_checks++;
        if ({st, mem_wen, mem_addr, mem_mask, mem_wdata, out_rdata} !== {6'b010000, 1'b0, 256'd0}) begin
            n_fail++;
            $display("FAIL reset outputs status=%b wen=%b addr=%h mask=%h wdata=%h rdata=%h",
                     st, mem_wen, mem_addr, mem_mask, mem_wdata, out_rdata);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_directed();
        run_txn(1'b0, 3'b011, 64'h8000_0010, 64'h5555, 64'h1122_3344_5566_7788, 0, 0, 0, "ld");
        run_txn(1'b0, 3'b000, 64'h8000_0013, 64'h0, 64'h0000_0000_8000_0000, 0, 0, 0, "lb");
        run_txn(1'b0, 3'b100, 64'h8000_0013, 64'h0, 64'h0000_0000_8000_0000, 1, 0, 0, "lbu");
        run_txn(1'b1, 3'b001, 64'h8000_0006, 64'hFFFF_ABCD, 64'h1234, 0, 1, 0, "sh");
        run_txn(1'b0, 3'b010, 64'h8000_0002, 64'h0, 64'h0, 0, 0, 1, "lw_mis");
        run_txn(1'b1, 3'b100, 64'h8000_0000, 64'h12, 64'h0, 0, 0, 0, "sbu_ill");
        run_txn(1'b0, 3'b111, 64'h8000_0001, 64'h0, 64'h0, 0, 0, 0, "f3_111");
        run_txn(1'b0, 3'b001, 64'h8000_0006, 64'h0, 64'hFEDC_0000_0000_0000, 0, 0, 0, "lh_hi");
    endtask

    task automatic test_resp_timeout_tie();
        run_txn(1'b0, 3'b110, 64'h8000_0004, 64'h0, 64'h8765_4321_0000_0000, 1, 1, 0, "tie");
    endtask

    task automatic test_hold_resp();
        run_txn(1'b0, 3'b010, 64'h8000_0004, 64'h0, 64'h8765_4321_0000_0000, 0, 0, 5, "hold5");
    endtask

    task automatic test_timeout();
        in_valid = 1'b1; in_wen = 1'b0; in_funct3 = 3'b011; in_addr = 64'h8000_0020;
        tick();
        in_valid = 1'b0;
        mem_req_ready = 1'b0;
        for (int i = 0; i < TMO; i++) begin
            n_checks++;
            if (st !== 6'b001000) begin
                n_fail++;
                $display("FAIL tmo_req cycle %0d status got=%b exp=001000", i, st);
            end
            tick();
        end
        n_checks++;
        if ({st, out_rdata} !== {6'b100001, 64'd0}) begin
            n_fail++;
            $display("FAIL tmo_resp status/rdata got=%b/%h exp=100001/0", st, out_rdata);
        end
        mem_resp_valid = 1'b1; mem_resp_data = 64'hDEAD_BEEF_CAFE_F00D;
        in_valid = 1'b1;
        tick();
        mem_resp_valid = 1'b0; in_valid = 1'b0;
        n_checks++;
        if ({st, out_rdata} !== {6'b100001, 64'd0}) begin
            n_fail++;
            $display("FAIL tmo_late_resp status/rdata got=%b/%h exp=100001/0", st, out_rdata);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        mem_resp_valid = 1'b1;
        tick();
        mem_resp_valid = 1'b0;
        n_checks++;
        if (st !== 6'b010000) begin
            n_fail++;
            $display("FAIL tmo_idle_resp status got=%b exp=010000", st);
        end
        // timeout counted across REQ and WAIT together
        in_valid = 1'b1; in_funct3 = 3'b000; in_addr = 64'h8000_0001;
        tick();
        in_valid = 1'b0;
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        for (int i = 0; i < TMO - 1; i++) begin
            n_checks++;
            if (st !== 6'b000000) begin
                n_fail++;
                $display("FAIL tmo_wait cycle %0d status got=%b exp=000000", i, st);
            end
            tick();
        end
        n_checks++;
        if ({st, out_rdata} !== {6'b100001, 64'd0}) begin
            n_fail++;
            $display("FAIL tmo_wait_resp status/rdata got=%b/%h exp=100001/0", st, out_rdata);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        in_valid = 1'b1; in_wen = 1'b0; in_funct3 = 3'b011; in_addr = 64'h8000_0040;
        tick();
        in_valid = 1'b0;
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        reset = 1'b1;
        #1;
        n_checks++;
        if (st !== 6'b010000) begin
            n_fail++;
            $display("FAIL rst_mid async status got=%b exp=010000", st);
        end
        tick();
        reset = 1'b0;
        mem_resp_valid = 1'b1; mem_resp_data = 64'h1;
        tick();
        mem_resp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (st !== 6'b010000) begin
                n_fail++;
                $display("FAIL rst_mid after cycle %0d status got=%b exp=010000", i, st);
            end
            tick();
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            logic        w = 1'($urandom);
            logic [2:0]  f3 = 3'($urandom);
            logic [63:0] a = {32'h8000_0000, $urandom};
            int          d1 = $urandom_range(0, 2);
            int          d2 = $urandom_range(0, 2 - d1);
            if ($urandom_range(0, 1) == 0) a = a - (a % m_bytes(f3));
            run_txn(w, f3, a, {$urandom, $urandom}, {$urandom, $urandom},
                    d1, d2, $urandom_range(0, 2), "rand");
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_resp_timeout_tie();
        test_hold_resp();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
